// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings and opcode constants for the CPU control sequencer.
package cpu_sequencer_pkg;

   localparam int OPCODE_WIDTH = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait cycle counter: clear has priority, counts while enabled, holds at the limit.
module seq_wait_timer #(
   parameter int LIMIT = 16,
   parameter int W     = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_limit
);

   logic [W-1:0] r_cnt;

   assign o_limit = (r_cnt == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)                  r_cnt <= '0;
      else if (i_clr)              r_cnt <= '0;
      else if (i_en && !o_limit)   r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the single-register CPU datapath with memory req/ack
// handshake and a bounded ack wait that halts the machine with a sticky bus error.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int OPCODE_WIDTH      = cpu_sequencer_pkg::OPCODE_WIDTH,
   parameter int WAIT_LIMIT        = 16,
   parameter int WAIT_CNT_WIDTH    = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   input  logic                         mem_ack,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic                         addr_sel,
   output logic                         pc_en,
   output logic                         mar_en,
   output logic                         ir_en,
   output logic                         mdr_en,
   output logic                         rf_we,
   output logic [2:0]                   state,
   output logic                         halted,
   output logic                         bus_error
);

   localparam logic [OPCODE_WIDTH-1:0] L_LOAD  = OPCODE_WIDTH'(OP_LOAD);
   localparam logic [OPCODE_WIDTH-1:0] L_STORE = OPCODE_WIDTH'(OP_STORE);
   localparam logic [OPCODE_WIDTH-1:0] L_HALT  = OPCODE_WIDTH'(OP_HALT);

   state_e                                      r_state;
   state_e                                      w_next;
   state_e                                      w_boundary;
   logic                                        r_bus_error;
   logic                                        w_timeout;
   logic                                        w_limit;
   logic                                        w_wait_clr;
   logic                                        w_wait_en;
   logic                                        w_in_mem_phase;
   logic [OPCODE_WIDTH-1:0]                     w_opcode;
   logic                                        w_is_load;
   logic                                        w_is_store;
   logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0]   w_unused_operand;

   assign w_opcode         = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
   assign w_unused_operand = instruction[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];
   assign w_is_load        = (w_opcode == L_LOAD);
   assign w_is_store       = (w_opcode == L_STORE);
   assign w_boundary       = run ? S_FETCH : S_IDLE;
   assign w_in_mem_phase   = (r_state == S_FETCH) || (r_state == S_MEM);

   // Counter restarts whenever a handshake state is freshly entered (incl. MEM -> FETCH).
   assign w_wait_clr = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));
   assign w_wait_en  = w_in_mem_phase && !mem_ack;

   seq_wait_timer #(
      .LIMIT (WAIT_LIMIT),
      .W     (WAIT_CNT_WIDTH)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_wait_clr),
      .i_en    (w_wait_en),
      .o_limit (w_limit)
   );

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE:   if (run) w_next = S_FETCH;
         S_FETCH: begin
            if (mem_ack)      w_next = S_DECODE;
            else if (w_limit) begin
               w_next    = S_HALT;
               w_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            if (w_opcode == L_HALT)           w_next = S_HALT;
            else if (w_is_load || w_is_store) w_next = S_MEM;
            else                              w_next = S_EXEC;
         end
         S_EXEC:   w_next = w_boundary;
         S_MEM: begin
            if (mem_ack)      w_next = w_is_load ? S_WB : w_boundary;
            else if (w_limit) begin
               w_next    = S_HALT;
               w_timeout = 1'b1;
            end
         end
         S_WB:     w_next = w_boundary;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_bus_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_timeout) r_bus_error <= 1'b1;
      end
   end

   // Capture strobes are gated by ack so the target register loads on the ack edge.
   assign mem_req   = w_in_mem_phase;
   assign addr_sel  = (r_state == S_MEM);
   assign mem_we    = (r_state == S_MEM) && w_is_store;
   assign pc_en     = (r_state == S_FETCH) && mem_ack;
   assign ir_en     = (r_state == S_FETCH) && mem_ack;
   assign mar_en    = (r_state == S_DECODE) && (w_is_load || w_is_store);
   assign mdr_en    = (r_state == S_MEM) && mem_ack && w_is_load;
   assign rf_we     = (r_state == S_EXEC) || (r_state == S_WB);
   assign halted    = (r_state == S_HALT);
   assign bus_error = r_bus_error;
   assign state     = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Cycle-table bench for cpu_sequencer: each row drives inputs, queues the expected
// outputs for that cycle, and the scenario task pops and compares them at the negedge.
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [31:0] instruction;
   logic        mem_ack;
   logic        mem_req, mem_we, addr_sel, pc_en, mar_en, ir_en, mdr_en, rf_we;
   logic [2:0]  state;
   logic        halted, bus_error;

   int errors = 0;
   int checks = 0;

   cpu_sequencer #(
      .INSTRUCTION_WIDTH (32),
      .OPCODE_WIDTH      (4),
      .WAIT_LIMIT        (4),
      .WAIT_CNT_WIDTH    (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .instruction (instruction),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .addr_sel    (addr_sel),
      .pc_en       (pc_en),
      .mar_en      (mar_en),
      .ir_en       (ir_en),
      .mdr_en      (mdr_en),
      .rf_we       (rf_we),
      .state       (state),
      .halted      (halted),
      .bus_error   (bus_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [9:0] s;   // req we asel pc mar ir mdr rf hlt err
   } obs_t;

   typedef struct {
      logic       rst;
      logic       run;
      logic [3:0] op;
      logic       ack;
      obs_t       exp;
   } row_t;

   localparam logic [9:0] N    = 10'b0000000000;
   localparam logic [9:0] REQ  = 10'b1000000000;
   localparam logic [9:0] WE   = 10'b0100000000;
   localparam logic [9:0] ASEL = 10'b0010000000;
   localparam logic [9:0] PC   = 10'b0001000000;
   localparam logic [9:0] MAR  = 10'b0000100000;
   localparam logic [9:0] IR   = 10'b0000010000;
   localparam logic [9:0] MDR  = 10'b0000001000;
   localparam logic [9:0] RF   = 10'b0000000100;
   localparam logic [9:0] HLT  = 10'b0000000010;
   localparam logic [9:0] ERR  = 10'b0000000001;
   localparam logic [3:0] OP_ALU = 4'h3;

   obs_t sb[$];

   function automatic row_t rw(logic rs, logic rn, logic [3:0] op, logic ak,
                               logic [2:0] st, logic [9:0] s);
      row_t r;
      r.rst = rs; r.run = rn; r.op = op; r.ack = ak;
      r.exp = '{st: st, s: s};
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st = state;
      o.s  = {mem_req, mem_we, addr_sel, pc_en, mar_en, ir_en, mdr_en, rf_we, halted, bus_error};
      return o;
   endfunction

   task automatic apply(input row_t r);
      rst_n       = r.rst;
      run         = r.run;
      mem_ack     = r.ack;
      instruction = {r.op, 28'($urandom)};
      sb.push_back(r.exp);
   endtask

   task automatic test_reset();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 0, OP_ALU, 0, S_IDLE, N));
      q.push_back(rw(0, 1, OP_ALU, 1, S_IDLE, N));
      q.push_back(rw(1, 0, OP_ALU, 1, S_IDLE, N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_delayed_ack();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_ALU, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH,  REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH,  REQ));
      q.push_back(rw(1, 1, OP_ALU, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_ALU, 0, S_DECODE, N));
      q.push_back(rw(1, 1, OP_ALU, 0, S_EXEC,   RF));
      q.push_back(rw(1, 0, OP_ALU, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 0, OP_ALU, 0, S_DECODE, N));
      q.push_back(rw(1, 0, OP_ALU, 0, S_EXEC,   RF));
      q.push_back(rw(1, 0, OP_ALU, 0, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL alu[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_LOAD, 1, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_LOAD, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_LOAD, 1, S_DECODE, MAR));
      q.push_back(rw(1, 1, OP_LOAD, 1, S_MEM,    REQ | ASEL | MDR));
      q.push_back(rw(1, 0, OP_LOAD, 1, S_WB,     RF));
      q.push_back(rw(1, 0, OP_LOAD, 1, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL load[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_back_to_back();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_STORE, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_STORE, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_STORE, 0, S_DECODE, MAR));
      q.push_back(rw(1, 1, OP_STORE, 0, S_MEM,    REQ | WE | ASEL));
      q.push_back(rw(1, 1, OP_STORE, 1, S_MEM,    REQ | WE | ASEL));
      q.push_back(rw(1, 0, OP_ALU,   1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 0, OP_ALU,   0, S_DECODE, N));
      q.push_back(rw(1, 0, OP_ALU,   0, S_EXEC,   RF));
      q.push_back(rw(1, 0, OP_ALU,   0, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL store[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_ALU, 0, S_IDLE,  N));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH, REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH, REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH, REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH, REQ));
      q.push_back(rw(1, 1, OP_ALU, 1, S_HALT,  HLT | ERR));
      q.push_back(rw(1, 0, OP_ALU, 0, S_HALT,  HLT | ERR));
      q.push_back(rw(0, 1, OP_ALU, 0, S_HALT,  HLT | ERR));
      q.push_back(rw(1, 0, OP_ALU, 0, S_IDLE,  N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL timeout[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ack_at_limit();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_ALU, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH,  REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH,  REQ));
      q.push_back(rw(1, 1, OP_ALU, 0, S_FETCH,  REQ));
      q.push_back(rw(1, 1, OP_ALU, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_ALU, 0, S_DECODE, N));
      q.push_back(rw(1, 0, OP_ALU, 0, S_EXEC,   RF));
      q.push_back(rw(1, 0, OP_ALU, 0, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ack_limit[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_HALT, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_HALT, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_HALT, 0, S_DECODE, N));
      q.push_back(rw(1, 0, OP_HALT, 0, S_HALT,   HLT));
      q.push_back(rw(1, 1, OP_HALT, 1, S_HALT,   HLT));
      q.push_back(rw(1, 0, OP_HALT, 1, S_HALT,   HLT));
      q.push_back(rw(0, 1, OP_HALT, 0, S_HALT,   HLT));
      q.push_back(rw(1, 0, OP_HALT, 0, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL halt[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_run_drop_and_reset_in_mem();
      row_t q[$]; obs_t o, e;
      q.push_back(rw(1, 1, OP_LOAD, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_LOAD, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_LOAD, 0, S_DECODE, MAR));
      q.push_back(rw(1, 0, OP_LOAD, 0, S_MEM,    REQ | ASEL));
      q.push_back(rw(1, 0, OP_LOAD, 1, S_MEM,    REQ | ASEL | MDR));
      q.push_back(rw(1, 0, OP_LOAD, 0, S_WB,     RF));
      q.push_back(rw(1, 1, OP_LOAD, 0, S_IDLE,   N));
      q.push_back(rw(1, 1, OP_LOAD, 1, S_FETCH,  REQ | PC | IR));
      q.push_back(rw(1, 1, OP_LOAD, 0, S_DECODE, MAR));
      q.push_back(rw(0, 1, OP_LOAD, 0, S_MEM,    REQ | ASEL));
      q.push_back(rw(1, 0, OP_LOAD, 1, S_IDLE,   N));
      foreach (q[i]) begin
         apply(q[i]); @(negedge clk);
         o = sample(); e = sb.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rundrop[%0d]: got st=%0d s=%b, want st=%0d s=%b", i, o.st, o.s, e.st, e.s);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      run         = 1'b0;
      mem_ack     = 1'b0;
      instruction = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_alu_delayed_ack();
      test_load();
      test_store_back_to_back();
      test_timeout();
      test_ack_at_limit();
      test_halt();
      test_run_drop_and_reset_in_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences the CPU's single-register datapath: program counter, memory address register, instruction register and memory data register. It drives each register's enable, selects the address-bus source and runs a req/ack handshake to memory. It decodes the opcode from the instruction register to choose the fetch/execute/memory/writeback path. A bounded wait counter detects a stalled memory and halts the machine with a sticky error.

Parameters:
INSTRUCTION_WIDTH, 32, width of the instruction register value presented for decode
OPCODE_WIDTH, 4, opcode field = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]
WAIT_LIMIT, 16, max cycles spent waiting for mem_ack before bus error (must be >= 1)
WAIT_CNT_WIDTH, 5, counter width; must hold WAIT_LIMIT

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  1 = keep sequencing instructions; sampled only at instruction boundaries
instruction  input  INSTRUCTION_WIDTH  current instruction register output
mem_ack  input  1  memory completes the current request this cycle
mem_req  output  1  memory request strobe
mem_we  output  1  1 = write (STORE), qualified by mem_req
addr_sel  output  1  0 = PC drives the address bus, 1 = MAR drives it
pc_en  output  1  PC register enable (increment load)
mar_en  output  1  MAR enable
ir_en  output  1  instruction register enable
mdr_en  output  1  MDR enable
rf_we  output  1  register-file write enable
state  output  3  current state encoding, for debug
halted  output  1  in HALT state
bus_error  output  1  sticky; memory ack timeout occurred

Behaviour:
- Interface fixed: one clock clk; reset rst_n is synchronous, active-low. No other reset.
- Reset: on any rising edge with rst_n=0, state=IDLE, wait_cnt=0, bus_error=0. All outputs 0 in the following cycle. Reset mid-handshake abandons the request.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. 7 is illegal and goes to IDLE.
- Outputs are decoded from state. pc_en, ir_en and mdr_en are additionally gated by mem_ack in the same cycle (Mealy), so the target register captures on the ack edge.
- IDLE: all strobes 0. run=1 -> FETCH.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack: ir_en=1, pc_en=1 that cycle, then -> DECODE. The instruction is valid in DECODE.
- DECODE (1 cycle): opcode OP_HALT -> HALT. OP_LOAD or OP_STORE: mar_en=1, then -> MEM. Any other opcode -> EXEC.
- EXEC (1 cycle): rf_we=1, then -> boundary.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE only. On mem_ack, LOAD: mdr_en=1, then -> WB. On mem_ack, STORE: -> boundary.
- WB (1 cycle): rf_we=1, then -> boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. Deasserting run mid-instruction completes the instruction.
- HALT: halted=1, all strobes 0. Held until reset; run is ignored.
- Wait counter: cleared on entry to FETCH or MEM; increments each cycle in FETCH/MEM with mem_ack=0. When it reaches WAIT_LIMIT-1 with no ack, the next edge sets bus_error=1 and goes to HALT, and mem_req drops.
- If mem_ack arrives in the same cycle the limit is hit, ack wins: normal transition, no error.
- mem_ack outside FETCH/MEM is ignored.
- mem_req stays asserted continuously until ack or timeout.

Decomposition:
- Shared package/params include: state encodings, OP_LOAD=4'h1, OP_STORE=4'h2, OP_HALT=4'hF, OPCODE_WIDTH.
- One natural sub-module: seq_wait_timer (clear/enable/limit-reached counter), instantiated once.
- The FSM and strobe decode stay in cpu_sequencer.

Test Plan:
- Reset, then run=1, ALU opcode 4'h3, mem_ack delayed 2 cycles -> FETCH lasts 3 cycles; ir_en=pc_en=1 only on the ack cycle; DECODE, then EXEC with rf_we=1; back in FETCH 6 cycles after start.
- LOAD (4'h1), acks immediate -> sequence FETCH, DECODE(mar_en), MEM(addr_sel=1, mdr_en on ack), WB(rf_we); mem_we=0 throughout.
- STORE (4'h2) -> MEM with mem_req=mem_we=addr_sel=1; after ack, no WB; next state FETCH.
- WAIT_LIMIT=4, mem_ack never asserted in FETCH -> mem_req high exactly 4 cycles; then bus_error=1, halted=1, state=6. Ack on the 4th cycle instead -> no error, DECODE.
- HALT opcode (4'hF) -> halted=1 permanently, run toggling has no effect; rst_n=0 for one edge -> IDLE, halted=0, bus_error=0.
- run dropped during MEM of a LOAD -> WB completes, then IDLE. rst_n=0 asserted while in MEM -> next cycle all strobes 0, state=0.
